spi_slave_stream: RTL and testbench

Parametrised SPI slave for the board-control path, successor to the fixed 96-bit single-word slave. Supports configurable word width, all four SPI modes (CPOL/CPHA), internal input synchronisers, and back-to-back multi-word streaming within one n_cs assertion. It also reports aborted transfers. Sits between the board SPI pins and the command/register decoder; fully synchronous to `clock`, never clocked by SCLK.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_slave_stream_if.sv | 26 ++
 rtl/sync_edge.sv | 29 ++
 rtl/spi_slave_stream.sv | 119 +++++++++++
 tb/tb_spi_slave_stream.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and mode helpers for the streaming SPI slave.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

    function automatic logic leading_is_rising(input logic cpol);
        return !cpol;
    endfunction

endpackage

// File: rtl/spi_slave_stream_if.sv
// Decoder-side bus of the SPI slave: word exchange strobes, status and FSM debug state.
interface spi_slave_stream_if #(
    parameter int WIDTH = 96
) ();
    // tx_load, rx_valid and aborted are single-cycle strobes without back-pressure: rx_data is
    // valid on the rx_valid cycle, tx_data is copied on the tx_load cycle and must then be
    // replaced before the next word boundary.
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             aborted;
    logic             busy;
    logic [15:0]      word_count;
    spi_pkg::state_t  state_dbg;

    modport slave (
        input  tx_data,
        output tx_load, rx_data, rx_valid, aborted, busy, word_count, state_dbg
    );

    modport master (
        output tx_data,
        input  tx_load, rx_data, rx_valid, aborted, busy, word_count, state_dbg
    );
endinterface

// File: rtl/sync_edge.sv
// N-stage input synchroniser with single-cycle rise/fall pulses on the synchronised level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Resetting to 0 keeps n_cs looking low after reset, so a held-low select never arms the slave.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_slave_stream.sv
// Parametrised SPI slave with multi-word streaming per chip select, clocked only by clock.
module spi_slave_stream import spi_pkg::*; #(
    parameter int WIDTH       = 96,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic mosi,
    input  logic sclk,
    input  logic n_cs,
    output logic miso,
    spi_slave_stream_if.slave bus
);
    localparam logic [1:0]    MODE     = spi_mode(CPOL, CPHA);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    state_t state_q, state_d;
    logic armed_q, first_q, rx_valid_q, aborted_q;
    logic [CW-1:0] bit_cnt_q, bit_cnt_after;
    logic [WIDTH-1:0] tx_shift_q, rx_shift_q, rx_data_q, rx_next;
    logic [15:0] word_count_q;
    logic any_edge, leading_edge, sample_edge, shift_edge;
    logic active, start, word_done, cut_short;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clock(clock), .reset(reset), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
        .clock(clock), .reset(reset), .d(n_cs), .q(ncs_s), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) mosi_sync_q <= '0;
        else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        any_edge      = sclk_rise | sclk_fall;
        leading_edge  = any_edge && (sclk_s == leading_is_rising(MODE[1]));
        sample_edge   = MODE[0] ? (any_edge && !leading_edge) : leading_edge;
        shift_edge    = any_edge && !sample_edge;
        active        = (state_q == ACTIVE);
        start         = !active && cs_fall && armed_q;
        word_done     = active && sample_edge && (bit_cnt_q == LAST_BIT);
        rx_next       = (rx_shift_q << 1) | WIDTH'(mosi_s);
        bit_cnt_after = bit_cnt_q;
        if (active && sample_edge) bit_cnt_after = word_done ? '0 : bit_cnt_q + 1'b1;
        // A sample edge in the same cycle as CS rise is counted first, so a completed word is not an abort.
        cut_short     = active && cs_rise && (bit_cnt_after != '0);
        state_d       = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            first_q      <= 1'b0;
            bit_cnt_q    <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            aborted_q    <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= 1'b0;
            aborted_q  <= 1'b0;
            if (!active) begin
                tx_shift_q <= bus.tx_data;
                if (ncs_s) armed_q <= 1'b1;
                if (start) begin
                    bit_cnt_q    <= '0;
                    word_count_q <= '0;
                    // With CPHA=0 the MSB is already on miso at CS fall, so the first trailing edge must shift.
                    first_q      <= MODE[0];
                end
            end else begin
                bit_cnt_q <= bit_cnt_after;
                aborted_q <= cut_short;
                if (sample_edge) rx_shift_q <= rx_next;
                if (word_done) begin
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                    if (word_count_q != 16'hFFFF) word_count_q <= word_count_q + 16'd1;
                    tx_shift_q <= bus.tx_data;
                    first_q    <= 1'b1;
                end else if (shift_edge) begin
                    if (first_q) first_q    <= 1'b0;
                    else         tx_shift_q <= tx_shift_q << 1;
                end
            end
        end
    end

    assign miso           = active & tx_shift_q[WIDTH-1];
    assign bus.tx_load    = start | word_done;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.aborted    = aborted_q;
    assign bus.busy       = active;
    assign bus.word_count = word_count_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: one 96-bit mode-0 slave and four 8-bit slaves, one per SPI mode.
module tb_spi_slave_stream;
    import spi_pkg::*;

    localparam int H  = 6;
    localparam int NT = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mosi  = 1'b0;
    logic sclk_p [NT];
    logic n_cs_p [NT];
    logic miso_w [NT];
    logic rxv [NT];
    logic abt [NT];
    logic txl [NT];
    logic busy_w [NT];
    logic [95:0] rxd [NT];
    logic [15:0] wc [NT];
    state_t st [NT];
    logic [95:0] tx_word = '0;

    logic [95:0] exp_q [$];
    logic [95:0] tx_q [$];
    logic [95:0] m_words [$];
    logic [95:0] s_words [$];
    logic [95:0] last_rx [NT];
    int n_checks = 0;
    int n_fail = 0;
    int abort_exp = 0;
    int cur_t = 0;

    always #5 clock = ~clock;

    spi_slave_stream_if #(.WIDTH(96)) bus96 ();
    assign bus96.tx_data = tx_word;
    spi_slave_stream #(.WIDTH(96)) dut96 (
        .clock(clock), .reset(reset), .mosi(mosi), .sclk(sclk_p[4]), .n_cs(n_cs_p[4]),
        .miso(miso_w[4]), .bus(bus96)
    );
    assign rxv[4] = bus96.rx_valid;
    assign abt[4] = bus96.aborted;
    assign txl[4] = bus96.tx_load;
    assign busy_w[4] = bus96.busy;
    assign rxd[4] = bus96.rx_data;
    assign wc[4] = bus96.word_count;
    assign st[4] = bus96.state_dbg;

    for (genvar g = 0; g < 4; g++) begin : g_w8
        spi_slave_stream_if #(.WIDTH(8)) bus ();
        assign bus.tx_data = tx_word[7:0];
        spi_slave_stream #(.WIDTH(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2))) dut (
            .clock(clock), .reset(reset), .mosi(mosi), .sclk(sclk_p[g]), .n_cs(n_cs_p[g]),
            .miso(miso_w[g]), .bus(bus)
        );
        assign rxv[g] = bus.rx_valid;
        assign abt[g] = bus.aborted;
        assign txl[g] = bus.tx_load;
        assign busy_w[g] = bus.busy;
        assign rxd[g] = {88'd0, bus.rx_data};
        assign wc[g] = bus.word_count;
        assign st[g] = bus.state_dbg;
    end

    function automatic int cpol_of(input int t);
        return (t < 4) ? t / 2 : 0;
    endfunction

    function automatic int cpha_of(input int t);
        return (t < 4) ? t % 2 : 0;
    endfunction

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic cs_low(input int t);
        n_cs_p[t] = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_high(input int t);
        wait_clk(H);
        n_cs_p[t] = 1'b1;
        wait_clk(3 * H);
    endtask

    // Master side: drives nbits of data MSB-first and returns what it read from miso.
    task automatic send_word(input int t, input int w, input logic [95:0] data, input int nbits,
                             input bit coincide, output logic [95:0] rd);
        int cpol = cpol_of(t);
        int cpha = cpha_of(t);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            if (cpha == 0) begin
                mosi = data[w-1-i];
                wait_clk(H);
                sclk_p[t] = (cpol == 0);
                if (coincide && i == nbits - 1) n_cs_p[t] = 1'b1;
                rd = {rd[94:0], miso_w[t]};
                wait_clk(H);
                sclk_p[t] = (cpol != 0);
            end else begin
                sclk_p[t] = (cpol == 0);
                mosi = data[w-1-i];
                wait_clk(H);
                sclk_p[t] = (cpol != 0);
                rd = {rd[94:0], miso_w[t]};
                wait_clk(H);
            end
        end
    endtask

    task automatic run_stream(input int t, input int w);
        logic [95:0] mask;
        logic [95:0] rd;
        mask = '1;
        mask = mask >> (96 - w);
        cur_t = t;
        tx_q = s_words;
        tx_word = tx_q.pop_front();
        wait_clk(2);
        cs_low(t);
        for (int i = 0; i < m_words.size(); i++) begin
            exp_q.push_back(m_words[i] & mask);
            last_rx[t] = m_words[i] & mask;
            send_word(t, w, m_words[i], w, 1'b0, rd);
            check("miso_word", rd & mask, s_words[i] & mask);
        end
        cs_high(t);
        check("word_count", {80'd0, wc[t]}, 96'(m_words.size()));
    endtask

    // Decoder: after each tx_load, present the next queued word.
    initial begin
        forever begin
            @(negedge clock);
            if (txl[cur_t] === 1'b1) begin
                @(posedge clock);
                #1;
                tx_word = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
            end
        end
    end

    // Monitor: every rx_valid consumes one expected word, every aborted one expected abort.
    initial begin
        forever begin
            @(negedge clock);
            for (int t = 0; t < NT; t++) begin
                if (rxv[t] === 1'b1) begin
                    if (exp_q.size() == 0) check("rx_valid_unexpected", {95'd0, rxv[t]}, 96'd0);
                    else check("rx_data", rxd[t], exp_q.pop_front());
                end
                if (abt[t] === 1'b1) begin
                    if (abort_exp > 0) begin
                        abort_exp--;
                        n_checks++;
                    end else begin
                        check("aborted_unexpected", {95'd0, abt[t]}, 96'd0);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] rd;
        int n;
        for (int t = 0; t < NT; t++) begin
            n_cs_p[t] = 1'b1;
            sclk_p[t] = (cpol_of(t) != 0);
            last_rx[t] = '0;
        end
        wait_clk(4);
        reset = 1'b0;
        wait_clk(1);
        check("reset_rx_data", rxd[4], 96'd0);
        check("reset_word_count", {80'd0, wc[4]}, 96'd0);
        check("reset_busy", {95'd0, busy_w[4]}, 96'd0);
        check("reset_miso", {95'd0, miso_w[4]}, 96'd0);
        check("reset_state", {95'd0, st[4]}, {95'd0, IDLE});
        wait_clk(2 * H);

        m_words.delete(); s_words.delete();
        m_words.push_back(96'h0123_4567_89AB_CDEF_0123_CDEF);
        s_words.push_back(96'hA5A5_A5A5_A5A5_A5A5_A5A5_A55A);
        run_stream(4, 96);

        for (int t = 0; t < 4; t++) begin
            m_words.delete(); s_words.delete();
            m_words.push_back(96'hC3);
            s_words.push_back(96'h3C);
            run_stream(t, 8);
        end

        for (int t = 0; t < 4; t++) begin
            m_words.delete(); s_words.delete();
            n = $urandom_range(2, 3);
            for (int i = 0; i < n; i++) begin
                m_words.push_back(96'($urandom_range(0, 255)));
                s_words.push_back(96'($urandom_range(0, 255)));
            end
            run_stream(t, 8);
        end

        m_words.delete(); s_words.delete();
        m_words.push_back(96'h11); m_words.push_back(96'h22); m_words.push_back(96'h33);
        s_words.push_back(96'hAA); s_words.push_back(96'hBB); s_words.push_back(96'hCC);
        run_stream(0, 8);

        // CS raised after 5 bits.
        cur_t = 0;
        tx_q.delete();
        tx_word = 96'h77;
        wait_clk(2);
        cs_low(0);
        abort_exp++;
        send_word(0, 8, 96'hF0, 5, 1'b0, rd);
        cs_high(0);
        check("abort_seen", 96'(abort_exp), 96'd0);
        check("abort_rx_hold", rxd[0], last_rx[0]);
        check("abort_word_count", {80'd0, wc[0]}, 96'd0);
        m_words.delete(); s_words.delete();
        m_words.push_back(96'h5A);
        s_words.push_back(96'h96);
        run_stream(0, 8);

        // Final sample edge and CS rise at the same instant.
        cur_t = 0;
        tx_q.delete();
        tx_word = 96'h81;
        wait_clk(2);
        cs_low(0);
        exp_q.push_back(96'h6E);
        last_rx[0] = 96'h6E;
        send_word(0, 8, 96'h6E, 8, 1'b1, rd);
        wait_clk(3 * H);
        check("coinc_miso", rd & 96'hFF, 96'h81);
        check("coinc_word_count", {80'd0, wc[0]}, 96'd1);
        check("coinc_busy", {95'd0, busy_w[0]}, 96'd0);

        // Reset mid-word with n_cs held low.
        cur_t = 0;
        tx_q.delete();
        tx_word = 96'h42;
        wait_clk(2);
        cs_low(0);
        send_word(0, 8, 96'hE7, 4, 1'b0, rd);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        for (int t = 0; t < NT; t++) last_rx[t] = '0;
        wait_clk(8);
        check("rst_mid_rx_data", rxd[0], last_rx[0]);
        check("rst_mid_word_count", {80'd0, wc[0]}, 96'd0);
        check("rst_mid_busy", {95'd0, busy_w[0]}, 96'd0);
        check("rst_mid_miso", {95'd0, miso_w[0]}, 96'd0);
        check("rst_mid_tx_load", {95'd0, txl[0]}, 96'd0);
        check("rst_mid_state", {95'd0, st[0]}, {95'd0, IDLE});
        send_word(0, 8, 96'hC9, 8, 1'b0, rd);
        check("rst_mid_still_idle", {95'd0, busy_w[0]}, 96'd0);
        cs_high(0);
        m_words.delete(); s_words.delete();
        m_words.push_back(96'h99);
        s_words.push_back(96'h24);
        run_stream(0, 8);

        wait_clk(20);
        check("exp_q_drained", 96'(exp_q.size()), 96'd0);
        check("aborts_drained", 96'(abort_exp), 96'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
